// File: rtl/mandelbrot_avn_wbuf.sv
// mandelbrot_avn_wbuf: write buffer between the renderer's Avalon-MM write master
// and the framebuffer SRAM arbiter. A DEPTH-entry FIFO absorbs arbiter stalls and a
// registered master port re-issues the buffered writes in strict order. When the FIFO
// is empty and the output register is free, an incoming write goes straight into the
// output register, so the first write still reaches the master side one cycle later.
// Optional feature macro: MANDELBROT_WBUF_FRAME_DONE_EN (pixel counter + frame_done pulse).
module mandelbrot_avn_wbuf #(
    parameter int AVN_AW       = 19,
    parameter int AVN_DW       = 16,
    parameter int DEPTH        = 8,
    parameter int FRAME_PIXELS = 307200
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [AVN_AW-1:0]        s_avn_address,
    input  logic                     s_avn_write,
    input  logic [AVN_DW-1:0]        s_avn_writedata,
    output logic                     s_avn_waitrequest,
    output logic [AVN_AW-1:0]        m_avn_address,
    output logic                     m_avn_write,
    output logic [AVN_DW-1:0]        m_avn_writedata,
    input  logic                     m_avn_waitrequest,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     frame_done
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = AVN_AW + AVN_DW;
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LEVEL_ZERO = {LW{1'b0}};
    localparam logic [LW-1:0] LEVEL_ONE  = LW'(1'b1);
    localparam logic [PW-1:0] PTR_ZERO   = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE    = PW'(1'b1);

    logic [EW-1:0] mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic          full_s;
    logic          push_s;
    logic          out_free_s;
    logic          load_s;
    logic [EW-1:0] load_entry_s;

    // Full while every FIFO slot holds a write; the output register is not counted.
    assign full_s            = (level_r == LEVEL_FULL);
    assign push_s            = s_avn_write && !full_s;
    // Output register can take a new entry when empty or being accepted this cycle.
    assign out_free_s        = !m_avn_write || !m_avn_waitrequest;
    // Load from the FIFO head, or bypass the incoming write when the FIFO is empty.
    assign load_s            = out_free_s && ((level_r != LEVEL_ZERO) || push_s);
    assign s_avn_waitrequest = full_s;
    assign fifo_level        = level_r;

    // Select the entry for the output register: FIFO head if any, else the incoming write.
    always_comb begin
        load_entry_s = {s_avn_address, s_avn_writedata};
        if (level_r != LEVEL_ZERO) begin
            load_entry_s = mem_r[rd_ptr_r];
        end else begin
            load_entry_s = {s_avn_address, s_avn_writedata};
        end
    end

    // Storage array; deliberately not reset, only the pointers qualify its contents.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {s_avn_address, s_avn_writedata};
        end
    end

    // Pointers and occupancy; a bypassed write advances both pointers and leaves level alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LEVEL_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (load_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, load_s})
                2'b10:   level_r <= level_r + LEVEL_ONE;
                2'b01:   level_r <= level_r - LEVEL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Registered master port; address/data only change when the register is free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_avn_write     <= 1'b0;
            m_avn_address   <= {AVN_AW{1'b0}};
            m_avn_writedata <= {AVN_DW{1'b0}};
        end else if (load_s) begin
            m_avn_write                       <= 1'b1;
            {m_avn_address, m_avn_writedata}  <= load_entry_s;
        end else if (out_free_s) begin
            m_avn_write <= 1'b0;
        end
    end

`ifdef MANDELBROT_WBUF_FRAME_DONE_EN
    localparam int CW = $clog2(FRAME_PIXELS);
    localparam logic [CW-1:0] PIX_LAST = CW'(FRAME_PIXELS - 1);
    localparam logic [CW-1:0] PIX_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] PIX_ONE  = CW'(1'b1);

    logic [CW-1:0] pix_cnt_r;
    logic          frame_done_r;
    logic          hs_s;

    assign hs_s       = m_avn_write && !m_avn_waitrequest;
    assign frame_done = frame_done_r;

    // Count accepted master writes; start wins over a same-cycle handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_cnt_r    <= PIX_ZERO;
            frame_done_r <= 1'b0;
        end else if (start) begin
            pix_cnt_r    <= PIX_ZERO;
            frame_done_r <= 1'b0;
        end else if (hs_s) begin
            if (pix_cnt_r == PIX_LAST) begin
                pix_cnt_r    <= PIX_ZERO;
                frame_done_r <= 1'b1;
            end else begin
                pix_cnt_r    <= pix_cnt_r + PIX_ONE;
                frame_done_r <= 1'b0;
            end
        end else begin
            frame_done_r <= 1'b0;
        end
    end
`else
    logic unused_s;

    assign frame_done = 1'b0;
    assign unused_s   = start ^ (FRAME_PIXELS == 0);
`endif

endmodule
